// File: rtl/bdm_link_if.sv
// bdm_link_if: host/sync-controller/command-engine signal bundle for bdm_link_ctrl.
// slave  = the link controller side, master = the surrounding logic side.
interface bdm_link_if;
  logic        connect_req;
  logic        sync_start;
  logic        sync_busy;
  logic [31:0] sync_length;
  logic        sync_length_is_ready;
  logic        cmd_req;
  logic        cmd_gnt;
  logic        cmd_done;
  logic [15:0] bit_time;
  logic        linked;
  logic        link_err;
  logic [1:0]  err_code;

  modport slave (
    input  connect_req, sync_busy, sync_length, sync_length_is_ready, cmd_req, cmd_done,
    output sync_start, cmd_gnt, bit_time, linked, link_err, err_code
  );

  modport master (
    output connect_req, sync_busy, sync_length, sync_length_is_ready, cmd_req, cmd_done,
    input  sync_start, cmd_gnt, bit_time, linked, link_err, err_code
  );
endinterface

// File: rtl/bdm_link_ctrl.sv
// bdm_link_ctrl: establishes the BDM link by running a sync measurement,
// derives bit_time from the measured low time, and arbitrates bkgd ownership
// with the command engine. Optional macro BDM_AUTO_RESYNC_EN adds a periodic
// re-sync after RESYNC_CYCLES idle cycles in LINKED.
module bdm_link_ctrl #(
  parameter int unsigned SYNC_MIN      = 128,
  parameter int unsigned SYNC_MAX      = 32'h0010_0000,
  parameter int unsigned SYNC_TIMEOUT  = 2_000_000,
  parameter int unsigned RESYNC_CYCLES = 1_000_000
) (
  input logic       clk,
  input logic       rst,
  bdm_link_if.slave bus
);

  localparam logic [31:0] L_MIN = 32'(SYNC_MIN);
  localparam logic [31:0] L_MAX = 32'(SYNC_MAX);
  localparam logic [31:0] L_TO  = 32'(SYNC_TIMEOUT);
  localparam logic [31:0] L_RS  = 32'(RESYNC_CYCLES);

  typedef enum logic [2:0] {IDLE, SYNC, LINKED, BUSY, ERR} state_t;

  state_t      r_state, w_next;
  logic        r_sync_start, r_gnt, r_linked, r_link_err, r_pend;
  logic [1:0]  r_err_code;
  logic [15:0] r_bit_time;
  logic [31:0] r_cnt;

  logic        w_ready, w_short, w_long, w_timeout, w_resync, w_sync_entry;
  logic [24:0] w_shift;
  logic [15:0] w_bt;

  assign w_ready      = bus.sync_length_is_ready;
  assign w_short      = bus.sync_length < L_MIN;
  assign w_long       = bus.sync_length > L_MAX;
  assign w_timeout    = (r_cnt == L_TO - 32'd1);
  assign w_shift      = bus.sync_length[31:7];
  assign w_bt         = (|w_shift[24:16]) ? 16'hFFFF : w_shift[15:0];
  assign w_sync_entry = (w_next == SYNC) && (r_state != SYNC);

`ifdef BDM_AUTO_RESYNC_EN
  logic [31:0] r_idle;

  // Count consecutive LINKED cycles; any state change restarts the count.
  always_ff @(posedge clk) begin
    if (!rst)                                      r_idle <= '0;
    else if (r_state == LINKED && w_next == LINKED) r_idle <= r_idle + 32'd1;
    else                                           r_idle <= '0;
  end

  assign w_resync = (r_state == LINKED) && (r_idle == L_RS - 32'd1);
`else
  logic w_unused_rs;
  assign w_unused_rs = ^L_RS;
  assign w_resync    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state; SYNC is never entered while the sync controller is still busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (bus.connect_req && !bus.sync_busy) w_next = SYNC;
      SYNC: begin
        if (w_ready)        w_next = (w_short || w_long) ? ERR : LINKED;
        else if (w_timeout) w_next = ERR;
      end
      LINKED: begin
        // Re-sync requests (host, pending, auto) beat a command request.
        if (bus.connect_req || r_pend || w_resync) begin
          if (!bus.sync_busy) w_next = SYNC;
        end else if (bus.cmd_req) begin
          w_next = BUSY;
        end
      end
      BUSY:   if (bus.cmd_done) w_next = LINKED;
      ERR:    if (bus.connect_req && !bus.sync_busy) w_next = SYNC;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state, plus bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_start <= 1'b0;
      r_gnt        <= 1'b0;
      r_linked     <= 1'b0;
      r_link_err   <= 1'b0;
      r_err_code   <= 2'd0;
      r_bit_time   <= 16'd0;
      r_pend       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync_start <= w_sync_entry;
      r_gnt        <= (w_next == BUSY);
      r_linked     <= (w_next == LINKED);
      r_cnt        <= (r_state == SYNC) ? r_cnt + 32'd1 : 32'd0;

      if (w_sync_entry)                              r_pend <= 1'b0;
      else if (r_state == BUSY && bus.connect_req)   r_pend <= 1'b1;

      if (w_sync_entry) begin
        r_link_err <= 1'b0;
        r_err_code <= 2'd0;
      end else if (r_state == SYNC && w_next == ERR) begin
        r_link_err <= 1'b1;
        r_err_code <= !w_ready ? 2'd3 : (w_short ? 2'd1 : 2'd2);
      end

      if (r_state == SYNC && w_next == LINKED) r_bit_time <= w_bt;
    end
  end

  assign bus.sync_start = r_sync_start;
  assign bus.cmd_gnt    = r_gnt;
  assign bus.linked     = r_linked;
  assign bus.link_err   = r_link_err;
  assign bus.err_code   = r_err_code;
  assign bus.bit_time   = r_bit_time;

endmodule

// File: tb/tb_bdm_link_ctrl.sv
// tb_bdm_link_ctrl: directed test of bdm_link_ctrl with small sync bounds.
// Build with +define+BDM_AUTO_RESYNC_EN to cover the auto re-sync variant.
module tb_bdm_link_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n_start  = 0;
  int   snap;

  bdm_link_if bus();

  bdm_link_ctrl #(
    .SYNC_MIN(16), .SYNC_MAX(4096), .SYNC_TIMEOUT(64), .RESYNC_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counter and busy-overlap monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.sync_start === 1'b1) n_start++;
    if (bus.sync_start === 1'b1 && bus.sync_busy === 1'b1) begin
      failures++;
      $error("FAIL start_while_busy observed=1 expected=0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_sync(input logic [31:0] len, input int dly);
    bus.connect_req = 1'b1;
    tick();
    bus.connect_req = 1'b0;
    repeat (dly) tick();
    bus.sync_length          = len;
    bus.sync_length_is_ready = 1'b1;
    tick();
    bus.sync_length_is_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.connect_req = 1'b0; bus.sync_busy = 1'b0; bus.sync_length = 32'd0;
    bus.sync_length_is_ready = 1'b0; bus.cmd_req = 1'b0; bus.cmd_done = 1'b0;
    tick(); tick();
    chk("rst_linked",   bus.linked,     0);
    chk("rst_link_err", bus.link_err,   0);
    chk("rst_err_code", bus.err_code,   0);
    chk("rst_bit_time", bus.bit_time,   0);
    chk("rst_gnt",      bus.cmd_gnt,    0);
    chk("rst_start",    bus.sync_start, 0);
    rst = 1'b1;
    tick();

    // Basic connect, ready after 10 cycles in SYNC, length 2048.
    bus.connect_req = 1'b1;
    tick();
    chk("start_pulse", bus.sync_start, 1);
    bus.connect_req = 1'b0;
    tick();
    chk("start_one_cycle", bus.sync_start, 0);
    repeat (8) tick();
    bus.sync_length = 32'd2048; bus.sync_length_is_ready = 1'b1;
    tick();
    bus.sync_length_is_ready = 1'b0;
    chk("c1_linked",   bus.linked,   1);
    chk("c1_bit_time", bus.bit_time, 16);
    chk("c1_err_code", bus.err_code, 0);
    chk("c1_starts",   n_start,      1);

    // Range checks, bounds inclusive.
    do_sync(32'd15, 3);
    chk("short_err",  bus.link_err, 1);
    chk("short_code", bus.err_code, 1);
    chk("short_lnk",  bus.linked,   0);
    chk("short_bt",   bus.bit_time, 16);
    do_sync(32'd4097, 3);
    chk("long_code", bus.err_code, 2);
    do_sync(32'd16, 3);
    chk("min_linked", bus.linked,   1);
    chk("min_err",    bus.link_err, 0);
    chk("min_bt",     bus.bit_time, 0);
    do_sync(32'd4096, 3);
    chk("max_linked", bus.linked,   1);
    chk("max_bt",     bus.bit_time, 32);

    // Timeout: 64 cycles in SYNC without ready.
    bus.connect_req = 1'b1;
    tick();
    bus.connect_req = 1'b0;
    repeat (60) tick();
    chk("to_not_yet", bus.link_err, 0);
    repeat (5) tick();
    chk("to_err",  bus.link_err, 1);
    chk("to_code", bus.err_code, 3);
    chk("to_lnk",  bus.linked,   0);
    do_sync(32'd256, 3);
    chk("rec_err",  bus.link_err, 0);
    chk("rec_code", bus.err_code, 0);
    chk("rec_bt",   bus.bit_time, 2);
    chk("rec_lnk",  bus.linked,   1);

    // Command grant, connect during BUSY deferred until cmd_done.
    bus.cmd_req = 1'b1;
    tick();
    chk("gnt_next", bus.cmd_gnt, 1);
    bus.cmd_req = 1'b0;
    snap = n_start;
    bus.connect_req = 1'b1;
    tick();
    bus.connect_req = 1'b0;
    tick();
    chk("busy_gnt_held", bus.cmd_gnt, 1);
    chk("busy_no_start", n_start, snap);
    bus.cmd_req = 1'b1; bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("done_gnt_low", bus.cmd_gnt, 0);
    tick();
    chk("pend_start", bus.sync_start, 1);
    chk("pend_no_gnt", bus.cmd_gnt,   0);
    bus.cmd_req = 1'b0;
    bus.sync_length = 32'd1024; bus.sync_length_is_ready = 1'b1;
    tick();
    bus.sync_length_is_ready = 1'b0;
    chk("pend_bt", bus.bit_time, 8);

    // Reset during BUSY.
    bus.cmd_req = 1'b1;
    tick();
    bus.cmd_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rstb_gnt", bus.cmd_gnt, 0);
    chk("rstb_lnk", bus.linked,  0);
    chk("rstb_bt",  bus.bit_time, 0);
    rst = 1'b1;
    snap = n_start;
    tick(); tick();
    chk("rstb_no_start", n_start, snap);
    bus.connect_req = 1'b1;
    tick();
    chk("idle_to_sync", bus.sync_start, 1);
    bus.connect_req = 1'b0;
    bus.sync_length = 32'd2048; bus.sync_length_is_ready = 1'b1;
    tick();
    bus.sync_length_is_ready = 1'b0;
    chk("rstb_relink", bus.linked, 1);

    // Sync controller busy holds off the re-sync.
    bus.sync_busy = 1'b1; bus.connect_req = 1'b1;
    tick(); tick();
    chk("sb_hold_lnk",   bus.linked,     1);
    chk("sb_hold_start", bus.sync_start, 0);
    bus.sync_busy = 1'b0;
    tick();
    chk("sb_release", bus.sync_start, 1);
    bus.connect_req = 1'b0;
    bus.sync_length = 32'd512; bus.sync_length_is_ready = 1'b1;
    tick();
    bus.sync_length_is_ready = 1'b0;
    chk("sb_bt", bus.bit_time, 4);

    // Idle LINKED behaviour.
    snap = n_start;
    repeat (45) tick();
    chk("idle_early", n_start, snap);
    repeat (10) tick();
`ifdef BDM_AUTO_RESYNC_EN
    chk("auto_resync", n_start, snap + 1);
    chk("auto_unlink", bus.linked, 0);
`else
    repeat (145) tick();
    chk("no_resync",   n_start,    snap);
    chk("stay_linked", bus.linked, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
